mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (instruction/data) memory arbiter with a single outstanding transaction.
// Optional round-robin arbitration via MEM_ARBITER_ROUND_ROBIN_EN; default is fixed d-priority.
module mem_arbiter #(
    parameter logic [31:0] ADDR_LEFT  = 32'h0000_0000,
    parameter logic [31:0] ADDR_RIGHT = 32'h0000_FFFF
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_valid,
    output logic        i_ready,
    input  logic [31:0] i_addr,
    input  logic        i_wen,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wmask,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_error,

    input  logic        d_valid,
    output logic        d_ready,
    input  logic [31:0] d_addr,
    input  logic        d_wen,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wmask,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_error,

    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;

    state_t      state;
    logic        owner_d;
    logic        rsp_valid;
    logic        rsp_error;
    logic [31:0] rsp_data;

    logic        d_wins;
    logic        grant_d;
    logic        grant_i;
    logic        accept;
    logic        fault;
    logic [31:0] sel_addr;
    logic        sel_wen;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_wmask;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic last_d;
    assign d_wins = !last_d;
`else
    assign d_wins = 1'b1;
`endif

    assign grant_d = d_valid && (!i_valid || d_wins);
    assign grant_i = i_valid && !grant_d;
    assign accept  = (state == IDLE) && !reset && (i_valid || d_valid);
    assign i_ready = (state == IDLE) && !reset && grant_i;
    assign d_ready = (state == IDLE) && !reset && grant_d;

    assign sel_addr  = grant_d ? d_addr  : i_addr;
    assign sel_wen   = grant_d ? d_wen   : i_wen;
    assign sel_wdata = grant_d ? d_wdata : i_wdata;
    assign sel_wmask = grant_d ? d_wmask : i_wmask;

    // Offset compare covers both inclusive bounds without a constant-zero comparison
    assign fault = (sel_addr[1:0] != 2'b00)
                || ((sel_addr - ADDR_LEFT) > (ADDR_RIGHT - ADDR_LEFT));

    assign i_rvalid = rsp_valid && !owner_d;
    assign d_rvalid = rsp_valid && owner_d;
    assign i_error  = rsp_error && !owner_d;
    assign d_error  = rsp_error && owner_d;
    assign i_rdata  = i_rvalid ? rsp_data : 32'h0;
    assign d_rdata  = d_rvalid ? rsp_data : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            owner_d   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            rsp_data  <= 32'h0;
            mem_valid <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wen   <= 1'b0;
            mem_wdata <= 32'h0;
            mem_wmask <= 4'h0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_d    <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            rsp_data  <= 32'h0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner_d <= grant_d;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                        last_d  <= grant_d;
`endif
                        if (fault) begin
                            // Error response is presented during the ERR cycle itself
                            state     <= ERR;
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b1;
                        end else begin
                            state     <= REQ;
                            mem_valid <= 1'b1;
                            mem_addr  <= sel_addr;
                            mem_wen   <= sel_wen;
                            mem_wdata <= sel_wdata;
                            mem_wmask <= sel_wmask;
                        end
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (mem_rvalid) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= mem_rdata;
                        state     <= IDLE;
                    end
                end
                ERR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected responses, a monitor pops and compares.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid, i_ready, i_wen, i_rvalid, i_error;
    logic [31:0] i_addr, i_wdata, i_rdata;
    logic [3:0]  i_wmask;
    logic        d_valid, d_ready, d_wen, d_rvalid, d_error;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wmask;
    logic        mem_valid, mem_ready, mem_wen, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_wen(i_wen),
        .i_wdata(i_wdata), .i_wmask(i_wmask), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .i_error(i_error),
        .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_wen(d_wen),
        .d_wdata(d_wdata), .d_wmask(d_wmask), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .d_error(d_error),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          acc_cycle;
        int          lat;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } mreq_t;

    rsp_t  iq[$];
    rsp_t  dq[$];
    mreq_t mq[$];
    byte   grants[$];

    int          checks = 0;
    int          failures = 0;
    int          cycle = 0;
    int          rv_count = 0;
    logic        mem_seen = 1'b0;
    logic [31:0] rsp_data = 32'h0;
    logic        hold_rsp = 1'b0;
    logic        stray = 1'b0;
    int          stall = 0;
    int          stall_cnt = 0;
    logic        hs;

    always @(posedge clk) cycle++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Downstream memory model: optional ready stall, response one cycle after handshake
    initial begin
        mem_ready  = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            hs = mem_valid && mem_ready;
            @(posedge clk);
            #1;
            if (hs) stall_cnt = 0;
            mem_rvalid = (hs && !hold_rsp) || stray;
            mem_rdata  = mem_rvalid ? rsp_data : 32'h0;
            if (mem_valid && stall_cnt < stall) begin
                mem_ready = 1'b0;
                stall_cnt++;
            end else begin
                mem_ready = 1'b1;
            end
        end
    end

    // Monitor
    initial begin
        rsp_t  r;
        mreq_t m;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (mem_valid) mem_seen = 1'b1;
                if (i_rvalid || d_rvalid) rv_count++;
                if (i_rvalid) begin
                    if (iq.size() == 0) check("i_unexpected_rvalid", 1, 0);
                    else begin
                        r = iq.pop_front();
                        check("i_rdata", i_rdata, r.data);
                        check("i_error", i_error, r.err);
                        check("i_latency", cycle - r.acc_cycle, r.lat);
                    end
                end else if (i_rdata != 0 || i_error) check("i_idle_outputs", {i_error, i_rdata}, 0);
                if (d_rvalid) begin
                    if (dq.size() == 0) check("d_unexpected_rvalid", 1, 0);
                    else begin
                        r = dq.pop_front();
                        check("d_rdata", d_rdata, r.data);
                        check("d_error", d_error, r.err);
                        check("d_latency", cycle - r.acc_cycle, r.lat);
                    end
                end else if (d_rdata != 0 || d_error) check("d_idle_outputs", {d_error, d_rdata}, 0);
                if (mem_valid && mem_ready) begin
                    if (mq.size() == 0) check("mem_unexpected_req", 1, 0);
                    else begin
                        m = mq.pop_front();
                        check("mem_addr", mem_addr, m.addr);
                        check("mem_wen", mem_wen, m.wen);
                        check("mem_wdata", mem_wdata, m.wdata);
                        check("mem_wmask", mem_wmask, m.wmask);
                    end
                end
            end
        end
    end

    task automatic issue(input bit is_d, input logic [31:0] addr, input logic wen,
                         input logic [31:0] wdata, input logic [3:0] wmask,
                         input logic [31:0] exp_data, input logic exp_err, input int lat,
                         input bit expect_rsp);
        bit   done = 0;
        rsp_t r;
        if (is_d) begin
            d_valid = 1; d_addr = addr; d_wen = wen; d_wdata = wdata; d_wmask = wmask;
        end else begin
            i_valid = 1; i_addr = addr; i_wen = wen; i_wdata = wdata; i_wmask = wmask;
        end
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (is_d ? d_ready : i_ready) begin
                done = 1;
                r = '{exp_data, exp_err, cycle, lat};
                if (expect_rsp) begin
                    if (is_d) dq.push_back(r);
                    else iq.push_back(r);
                end
                if (!exp_err) mq.push_back('{addr, wen, wdata, wmask});
            end
            @(posedge clk);
            #1;
        end
        if (is_d) d_valid = 0;
        else i_valid = 0;
        if (!done) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((iq.size() != 0 || dq.size() != 0 || mq.size() != 0) && k < 100) begin
            @(posedge clk);
            k++;
        end
        if (k >= 100) check("response_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset(input int n);
        @(posedge clk);
        #1;
        reset = 1;
        repeat (n) @(posedge clk);
        #1;
        reset = 0;
    endtask

    initial begin
        byte exp_g[4];
        int  rv_before;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        exp_g = '{"d", "i", "d", "i"};
`else
        exp_g = '{"d", "d", "d", "d"};
`endif
        reset = 1;
        i_valid = 1; i_addr = 32'h100; i_wen = 0; i_wdata = 0; i_wmask = 4'hF;
        d_valid = 1; d_addr = 32'h200; d_wen = 0; d_wdata = 0; d_wmask = 4'hF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", {i_ready, d_ready}, 0);
        check("reset_rsp", {i_rvalid, d_rvalid, i_error, d_error}, 0);
        check("reset_rdata", {i_rdata, d_rdata}, 0);
        check("reset_mem_ctl", {mem_valid, mem_wen, mem_wmask}, 0);
        check("reset_mem_data", {mem_addr, mem_wdata}, 0);
        @(posedge clk);
        #1;
        i_valid = 0; d_valid = 0; reset = 0;
        @(posedge clk);
        #1;

        // Basic read, minimum latency
        rsp_data = 32'hDEADBEEF;
        issue(0, 32'h100, 0, 32'h0, 4'hF, 32'hDEADBEEF, 0, 3, 1);
        wait_idle();

        // Out-of-range write faults without downstream access
        mem_seen = 0;
        issue(1, 32'h0001_0000, 1, 32'hCAFEF00D, 4'hF, 32'h0, 1, 1, 1);
        wait_idle();
        check("range_fault_no_mem", mem_seen, 0);

        // Misaligned fetch faults without downstream access
        mem_seen = 0;
        issue(0, 32'h102, 0, 32'h0, 4'hF, 32'h0, 1, 1, 1);
        wait_idle();
        check("align_fault_no_mem", mem_seen, 0);

        // Both inclusive bounds are legal
        rsp_data = 32'h11112222;
        issue(1, 32'h0000_FFFC, 1, 32'hA1B2C3D4, 4'h3, 32'h11112222, 0, 3, 1);
        wait_idle();
        rsp_data = 32'h0BADF00D;
        issue(0, 32'h0, 0, 32'h0, 4'hF, 32'h0BADF00D, 0, 3, 1);
        wait_idle();

        // Downstream stall: fields stable, no ready while busy
        stall = 5;
        rsp_data = 32'h55AA55AA;
        issue(1, 32'h304, 1, 32'h12345678, 4'h5, 32'h55AA55AA, 0, 8, 1);
        i_valid = 1; i_addr = 32'h102;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_fields", {mem_valid, mem_ready, mem_addr, mem_wdata, mem_wmask},
                  {1'b1, 1'b0, 32'h304, 32'h12345678, 4'h5});
            check("stall_ready", {i_ready, d_ready}, 0);
        end
        @(posedge clk);
        #1;
        i_valid = 0;
        wait_idle();
        stall = 0;

        // Arbitration from reset under continuous contention
        pulse_reset(2);
        rsp_data = 32'hA5A50001;
        i_valid = 1; i_addr = 32'h400; i_wen = 0; i_wmask = 4'hF;
        d_valid = 1; d_addr = 32'h500; d_wen = 0; d_wmask = 4'hF;
        for (int k = 0; k < 60 && grants.size() < 4; k++) begin
            @(negedge clk);
            if (d_valid && d_ready) begin
                grants.push_back("d");
                dq.push_back('{32'hA5A50001, 1'b0, cycle, 3});
                mq.push_back('{32'h500, 1'b0, d_wdata, 4'hF});
            end
            if (i_valid && i_ready) begin
                grants.push_back("i");
                iq.push_back('{32'hA5A50001, 1'b0, cycle, 3});
                mq.push_back('{32'h400, 1'b0, i_wdata, 4'hF});
            end
            @(posedge clk);
            #1;
        end
        i_valid = 0; d_valid = 0;
        check("grant_count", grants.size(), 4);
        for (int k = 0; k < 4; k++)
            if (k < grants.size()) check("grant_order", grants[k], exp_g[k]);
        wait_idle();

        // Reset while awaiting the response, then a stray response
        hold_rsp = 1;
        rsp_data = 32'h77777777;
        issue(0, 32'h600, 0, 32'h0, 4'hF, 32'h0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        rv_before = rv_count;
        @(negedge clk);
        check("post_reset_mem_valid", mem_valid, 0);
        stray = 1;
        @(negedge clk);
        stray = 0;
        repeat (4) @(negedge clk);
        check("stray_rsp_ignored", rv_count - rv_before, 0);
        hold_rsp = 0;
        @(posedge clk);
        #1;
        rsp_data = 32'h13579BDF;
        issue(0, 32'h604, 0, 32'h0, 4'hF, 32'h13579BDF, 0, 3, 1);
        wait_idle();

        check("queues_drained", iq.size() + dq.size() + mq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
